display_mux4: RTL

Display-side consumer of the calculator's `pos`/`data`/`status` output interface. It captures digit writes into a four-entry digit memory, decodes each entry to seven-segment patterns, and time-multiplexes them onto a common-anode 4-digit display. The block sits between the calculator core and the board's segment/anode pins.

---
 rtl/display_mux4.sv | 113 +++++++++++
 1 files changed

// File: rtl/display_mux4.sv
// Latches calculator digit writes, decodes them to active-low seven-segment
// patterns and scans them onto a common-anode 4-digit display with busy dp and error blink.
`timescale 1ns/1ps
module display_mux4 #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic [3:0] pos,
  input  logic [3:0] data,
  input  logic [1:0] status,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = $clog2(2 * BLINK_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(2 * BLINK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_HALF = BLK_W'(BLINK_DIV);

  logic [3:0][3:0]   code_q, code_d;
  logic [3:0]        vld_q, vld_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic [1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [BLK_W-1:0]  blk_cur;
  logic              err_q, err_d;
  logic              is_err;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    code_d = code_q;
    vld_d  = vld_q;
    if (clr) begin
      vld_d = '0;
    end else if (pos[3:2] == 2'b00) begin
      code_d[pos[1:0]] = data;
      vld_d[pos[1:0]]  = 1'b1;
    end

    ref_d = (ref_q == REF_LAST) ? '0 : ref_q + 1'b1;
    idx_d = (ref_q == REF_LAST) ? idx_q + 2'd1 : idx_q;

    // Entering error forces this cycle's count to zero so the first on-phase is full length.
    is_err  = (status == 2'b10);
    err_d   = is_err;
    blk_cur = (is_err && !err_q) ? '0 : blk_q;
    blk_d   = (blk_cur == BLK_LAST) ? '0 : blk_cur + 1'b1;

    // Anode and segments come from the same index so they always switch together.
    an_d  = (is_err && (blk_cur >= BLK_HALF)) ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = vld_q[idx_q] ? hex7(code_q[idx_q]) : 7'b1111111;
    dp_d  = !((status == 2'b01) && (idx_q == 2'd0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code_q <= '0;
      vld_q  <= '0;
      ref_q  <= '0;
      idx_q  <= '0;
      blk_q  <= '0;
      err_q  <= 1'b0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      code_q <= code_d;
      vld_q  <= vld_d;
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      blk_q  <= blk_d;
      err_q  <= err_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
